// File: rtl/sponge_pkg.sv
// sponge_pkg: shared types and constants for the sponge hash controller.
//   sponge_state_e : FSM states of sponge_ctrl (also exported on dbg_state)
//   state_sel_e    : datapath state-register operation select
//   DEFAULT_ROUNDS : permutation rounds per permutation
package sponge_pkg;

  localparam int DEFAULT_ROUNDS = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_XOR     = 3'd2,
    ST_PERM    = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_SQPERM  = 3'd5,
    ST_DONE    = 3'd6
  } sponge_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_CLEAR = 2'd1,
    SEL_XOR   = 2'd2,
    SEL_PERM  = 2'd3
  } state_sel_e;

endpackage

// File: rtl/sponge_round_ctr.sv
// sponge_round_ctr: permutation round counter shared by absorb and squeeze.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : pulse in the cycle before round 0; round 0 follows next cycle
//   round_idx    : current round, 0..ROUNDS-1 while running, 0 when idle
//   last         : high during round ROUNDS-1
module sponge_round_ctr
  import sponge_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] round_idx,
  output logic       last
);

  logic running;

  assign last = running && (round_idx == 5'(ROUNDS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      running   <= 1'b0;
      round_idx <= '0;
    end else if (start) begin
      running   <= 1'b1;
      round_idx <= '0;
    end else if (running) begin
      if (last) begin
        // Park at 0 so the index reads clean outside a permutation.
        running   <= 1'b0;
        round_idx <= '0;
      end else begin
        round_idx <= round_idx + 5'd1;
      end
    end
  end

endmodule

// File: rtl/sponge_ctrl.sv
// sponge_ctrl: SHAKE128/256 sponge sequencer. Buffers message blocks, then
// drives CLEAR, per-block XOR + permutation, and squeeze of the requested
// number of output blocks.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   mode                  : 0 SHAKE128, 1 SHAKE256, latched into rate_sel
//   in_valid/in_last/in_ready : message block input
//   out_blocks            : output blocks requested, sampled with the last block
//   out_valid/out_ready   : output block handshake
//   wr_addr/wren          : block buffer write port (combinational)
//   rd_addr               : block buffer read address for XOR
//   state_sel/round_idx   : datapath operation select and round
//   rate_sel              : latched mode
//   busy/full/done        : status
//   dbg_state             : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and ready while valid is low has no effect.
module sponge_ctrl
  import sponge_pkg::*;
#(
  parameter int DEPTH  = 7,
  parameter int ROUNDS = DEFAULT_ROUNDS,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mode,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [7:0]    out_blocks,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] wr_addr,
  output logic          wren,
  output logic [AW-1:0] rd_addr,
  output logic [1:0]    state_sel,
  output logic [4:0]    round_idx,
  output logic          rate_sel,
  output logic          busy,
  output logic          full,
  output logic          done,
  output sponge_state_e dbg_state
);

  // Wide enough to hold DEPTH itself (count after a forced-last accept).
  localparam int CW = $clog2(DEPTH + 1);

  sponge_state_e state;
  state_sel_e    sel_q;
  logic [CW-1:0] count;
  logic [CW-1:0] nblk;
  logic [CW-1:0] blk;
  logic [7:0]    rem;
  logic          accept;
  logic          rnd_start;
  logic          rnd_last;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign wren      = accept;
  assign wr_addr   = AW'(count);
  assign rd_addr   = AW'(blk);
  assign full      = (state == ST_IDLE) && (count == CW'(DEPTH - 1));
  assign state_sel = sel_q;
  assign dbg_state = state;

  // Kick the round counter on the edge that enters PERM or SQPERM.
  assign rnd_start = (state == ST_XOR) ||
                     ((state == ST_SQUEEZE) && out_ready && (rem != 8'd1));

  sponge_round_ctr #(.ROUNDS(ROUNDS)) u_round_ctr (
    .clock     (clock),
    .reset     (reset),
    .start     (rnd_start),
    .round_idx (round_idx),
    .last      (rnd_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_q     <= SEL_HOLD;
      count     <= '0;
      nblk      <= '0;
      blk       <= '0;
      rem       <= '0;
      rate_sel  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            count <= count + 1'b1;
            if (count == '0) rate_sel <= mode;
            // The buffer filling up ends the message even without in_last.
            if (in_last || (count == CW'(DEPTH - 1))) begin
              nblk  <= count + 1'b1;
              rem   <= (out_blocks == 8'd0) ? 8'd1 : out_blocks;
              blk   <= '0;
              busy  <= 1'b1;
              sel_q <= SEL_CLEAR;
              state <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          sel_q <= SEL_XOR;
          state <= ST_XOR;
        end
        ST_XOR: begin
          sel_q <= SEL_PERM;
          state <= ST_PERM;
        end
        ST_PERM: begin
          if (rnd_last) begin
            blk <= blk + 1'b1;
            if ((blk + 1'b1) < nblk) begin
              sel_q <= SEL_XOR;
              state <= ST_XOR;
            end else begin
              sel_q     <= SEL_HOLD;
              out_valid <= 1'b1;
              state     <= ST_SQUEEZE;
            end
          end
        end
        ST_SQUEEZE: begin
          if (out_ready) begin
            rem       <= rem - 8'd1;
            out_valid <= 1'b0;
            if (rem == 8'd1) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              sel_q <= SEL_PERM;
              state <= ST_SQPERM;
            end
          end
        end
        ST_SQPERM: begin
          if (rnd_last) begin
            sel_q     <= SEL_HOLD;
            out_valid <= 1'b1;
            state     <= ST_SQUEEZE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          count <= '0;
          state <= ST_IDLE;
        end
        default: begin
          sel_q     <= SEL_HOLD;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sponge_ctrl.sv
// tb_sponge_ctrl: directed bench for sponge_ctrl (DEPTH 7, ROUNDS 24).
// Stimulus pushes expected output events and XOR read addresses into queues;
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sponge_ctrl;
  import sponge_pkg::*;

  localparam int DEPTH  = 7;
  localparam int ROUNDS = 24;
  localparam int AW     = $clog2(DEPTH);

  logic          clock;
  logic          reset;
  logic          mode;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [7:0]    out_blocks;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] wr_addr;
  logic          wren;
  logic [AW-1:0] rd_addr;
  logic [1:0]    state_sel;
  logic [4:0]    round_idx;
  logic          rate_sel;
  logic          busy;
  logic          full;
  logic          done;
  sponge_state_e dbg_state;

  sponge_ctrl #(.DEPTH(DEPTH), .ROUNDS(ROUNDS)) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_blocks (out_blocks),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wr_addr    (wr_addr),
    .wren       (wren),
    .rd_addr    (rd_addr),
    .state_sel  (state_sel),
    .round_idx  (round_idx),
    .rate_sel   (rate_sel),
    .busy       (busy),
    .full       (full),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Scoreboard: {last output, expected rate_sel, latency in edges}
  logic [15:0] exp_q[$];
  logic [2:0]  xq[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ref_cyc = 0;
  int done_due = -1;
  int stall_left = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for one hash: first latency is hand-computed per case,
  // later blocks follow their previous handshake by one 24-round SQPERM.
  task automatic push_hash(input int nblk, input logic rate, input int nout, input int first_lat);
    for (int i = 0; i < nblk; i++) xq.push_back(3'(i));
    for (int j = 0; j < nout; j++)
      exp_q.push_back({(j == nout - 1) ? 1'b1 : 1'b0, rate, 14'((j == 0) ? first_lat : 24)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_block(input logic last_bit, input logic final_blk, input logic m,
                            input logic [7:0] ob, input int exp_addr);
    @(posedge clock); #1;
    in_valid   = 1'b1;
    in_last    = last_bit;
    mode       = m;
    out_blocks = ob;
    @(negedge clock);
    chk("in_ready", in_ready, 1);
    chk("wren", wren, 1);
    chk("wr_addr", wr_addr, exp_addr);
    chk("full", full, (exp_addr == DEPTH - 1) ? 1 : 0);
    @(posedge clock); #1;
    if (final_blk) ref_cyc = cyc;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    mode       = ~m;       // later mode changes must be ignored
    out_blocks = 8'hA5;    // sampled only with the last block
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && xq.size() == 0 && !busy && dbg_state == ST_IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  // ---------------- consumer ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (stall_left > 0 && out_valid) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [15:0] e;
    logic prev_valid, prev_ready, cur_last;
    int perm_run;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    cur_last   = 1'b0;
    perm_run   = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        perm_run   = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
      end else begin
        if (state_sel == 2'd2) begin
          if (xq.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL xor_unexpected: got rd_addr %0d expected no XOR", rd_addr);
          end else begin
            chk("rd_addr", rd_addr, xq.pop_front());
          end
        end
        if (state_sel == 2'd3) begin
          chk("round_idx", round_idx, perm_run);
          perm_run++;
        end else if (perm_run != 0) begin
          chk("perm_len", perm_run, ROUNDS);
          perm_run = 0;
        end
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL out_unexpected: got out_valid 1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("out_latency", cyc - ref_cyc, {18'd0, e[13:0]});
            chk("rate_sel", rate_sel, e[14]);
            cur_last = e[15];
          end
        end
        if (prev_valid && !prev_ready) chk("hold_valid", out_valid, 1);
        if (out_valid && out_ready) begin
          ref_cyc = cyc + 1;
          if (cur_last) done_due = cyc + 1;
        end
        if (done || cyc == done_due) chk("done", done, (cyc == done_due) ? 1 : 0);
        prev_valid = out_valid;
        prev_ready = out_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    reset      = 1'b1;
    mode       = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_blocks = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state_sel", state_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_rate_sel", rate_sel, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wren", wren, 0);

    // One block, one output: out_valid 26 edges after accept.
    push_hash(1, 1'b0, 1, 26);
    send_block(1'b1, 1'b1, 1'b0, 8'd1, 0);
    @(negedge clock);
    chk("clear_sel", state_sel, 1);
    chk("clear_busy", busy, 1);
    chk("clear_in_ready", in_ready, 0);
    wait_idle("t1_complete");

    // Three blocks, mode toggled after the first: rate stays 1, latency 76.
    push_hash(3, 1'b1, 1, 76);
    send_block(1'b0, 1'b0, 1'b1, 8'd9, 0);
    send_block(1'b0, 1'b0, 1'b0, 8'd9, 1);
    send_block(1'b1, 1'b1, 1'b0, 8'd1, 2);
    // A block offered while busy must not be written.
    in_valid = 1'b1;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("busy_wren", wren, 0);
      chk("busy_in_ready", in_ready, 0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle("t2_complete");

    // Seven blocks without in_last: seventh forces last, nblk 7, latency 176.
    push_hash(7, 1'b0, 2, 176);
    for (int i = 0; i < 7; i++)
      send_block(1'b0, (i == 6) ? 1'b1 : 1'b0, 1'b0, 8'd2, i);
    @(negedge clock);
    chk("forced_full", full, 0);
    chk("forced_busy", busy, 1);
    wait_idle("t3_complete");

    // Three outputs with a 5-cycle consumer stall on the first.
    push_hash(1, 1'b1, 3, 26);
    stall_left = 5;
    send_block(1'b1, 1'b1, 1'b1, 8'd3, 0);
    wait_idle("t4_complete");

    // Reset in the middle of PERM at round 10.
    xq.push_back(3'd0);
    send_block(1'b1, 1'b1, 1'b1, 8'd4, 0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (state_sel == 2'd3 && round_idx == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_round10", found, 1);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_state_sel", state_sel, 0);
    chk("abort_round_idx", round_idx, 0);
    chk("abort_rate_sel", rate_sel, 0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    xq.delete();
    done_due = -1;

    // out_blocks = 0 still yields exactly one output block.
    push_hash(1, 1'b0, 1, 26);
    send_block(1'b1, 1'b1, 1'b0, 8'd0, 0);
    wait_idle("t5_complete");
    repeat (40) @(negedge clock);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sponge_ctrl.md
SPONGE_CTRL -- requirements
Module: sponge_ctrl

Interface
REQ-001 Parameter DEPTH, 7: block buffer slots, i.e. maximum message blocks per hash; DEPTH >= 2.
REQ-002 Parameter ROUNDS, 24: permutation rounds per permutation.
REQ-003 Parameter AW, $clog2(DEPTH): buffer address width.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mode  in  1  0 = SHAKE128 (rate 1344), 1 = SHAKE256 (rate 1088).
REQ-007 in_valid  in  1  message block present.
REQ-008 in_last  in  1  qualifies in_valid; marks the final block.
REQ-009 in_ready  out  1  block accepted when in_valid && in_ready.
REQ-010 out_blocks  in  8  requested output blocks; sampled when the last block is accepted.
REQ-011 out_valid  out  1  output block readable from the state.
REQ-012 out_ready  in  1  consumer takes the block when out_valid && out_ready.
REQ-013 wr_addr  out  AW  buffer write address; wren  out  1  buffer write enable.
REQ-014 rd_addr  out  AW  buffer read address for the absorbed block.
REQ-015 state_sel  out  2  0 HOLD, 1 CLEAR, 2 XOR block at rd_addr into the state, 3 PERMUTE one round.
REQ-016 round_idx  out  5  current round index; valid while state_sel == 3.
REQ-017 rate_sel  out  1  latched mode for the datapath.
REQ-018 busy, full, done  out  1 each  status flags.

Function
REQ-019 The FSM SHALL have the states IDLE, CLEAR, XOR, PERM, SQUEEZE, SQPERM and DONE; busy == (state != IDLE).
REQ-020 IDLE: in_ready SHALL equal 1; wren and wr_addr SHALL be combinational: wren = in_valid && in_ready, wr_addr = count; count increments on each accept.
REQ-021 The first accepted block SHALL latch mode into rate_sel; mode changes at any other time SHALL be ignored.
REQ-022 Acceptance with in_last = 1, or acceptance of the block that makes count == DEPTH (forced last), SHALL latch nblk = count+1 and rem = max(out_blocks,1) and go to CLEAR.
REQ-023 full SHALL equal (count == DEPTH-1) in IDLE, and 0 elsewhere.
REQ-024 CLEAR SHALL last one cycle with state_sel = 1 and blk = 0, then go to XOR.
REQ-025 XOR SHALL last one cycle with state_sel = 2 and rd_addr = blk, then go to PERM.
REQ-026 PERM SHALL last ROUNDS cycles with state_sel = 3 and round_idx = 0..ROUNDS-1.
REQ-027 At the end of PERM, blk SHALL increment; the FSM SHALL return to XOR if blk < nblk, else go to SQUEEZE.
REQ-028 Latency: out_valid SHALL first rise exactly 1 + nblk*(ROUNDS+1) clock edges after the last block's accept edge.
REQ-029 SQUEEZE: out_valid = 1 and state_sel = 0. On handshake, rem decrements; if rem becomes 0 the FSM goes to DONE, else to SQPERM.
REQ-030 SQPERM SHALL match PERM (ROUNDS cycles, state_sel = 3, out_valid = 0) and then return to SQUEEZE.
REQ-031 DONE SHALL last one cycle with done = 1, clear count, and return to IDLE.
REQ-032 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE and out_ready while out_valid = 0 SHALL be ignored.
REQ-033 All counters SHALL be sized so that ROUNDS-1, DEPTH and 255 never wrap.

Reset
REQ-034 reset SHALL put the FSM in IDLE from any state in one cycle, discarding any operation in progress.
REQ-035 Reset values SHALL be: count, blk, rem, round_idx, rd_addr = 0; state_sel = 0; rate_sel = 0; out_valid, busy, full and done = 0; in_ready = 1 in the first cycle after reset.

Structure
REQ-036 A package sponge_pkg SHALL hold the FSM state enum, the state_sel encodings (HOLD, CLEAR, XOR, PERM) and the default ROUNDS constant.
REQ-037 The round counter SHALL be a sub-module, sponge_round_ctr (start in; round_idx and last out), shared by PERM and SQPERM.

Verification
REQ-038 Reset mid-PERM at round 10 -> next cycle state IDLE, busy = 0, in_ready = 1, state_sel = 0.
REQ-039 One block with in_last, out_blocks = 1, ROUNDS = 24 -> CLEAR 1, XOR 1, PERM 24 cycles; out_valid at edge 26; done pulses one cycle after the out handshake.
REQ-040 Three blocks, last on the third -> rd_addr takes 0, 1, 2 in the XOR cycles; out_valid at edge 76.
REQ-041 DEPTH = 7, seven blocks with in_last = 0 -> full = 1 after the sixth accept; the seventh accept forces last with nblk = 7.
REQ-042 out_blocks = 3, out_ready held low for 5 cycles -> out_valid stays high; three handshakes separated by 24-cycle SQPERM gaps; out_blocks = 0 -> exactly one output block.
REQ-043 mode toggled during ABSORB -> rate_sel keeps the value latched at the first accepted block.
